// File: rtl/rx_uart_ctrl.sv
// rx_uart_ctrl: buffers bytes from the UART RX core in a show-ahead FIFO and posts status to the control register.
// Optional feature: define RX_UART_IRQ_EN to add the registered irq_o output.
module rx_uart_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rx_done_i,
  input  logic [DATA_WIDTH-1:0]         rx_data_i,
  input  logic                          rd_pop_i,
  input  logic                          ovf_clr_i,
  output logic [DATA_WIDTH-1:0]         rx_data_o,
  output logic                          rx_empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count_o,
  output logic [1:0]                    ctrl_status_o,
  output logic                          sel_control,
  output logic                          we_reg_control_o
`ifdef RX_UART_IRQ_EN
  ,
  output logic                          irq_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, STORE, FLAG} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_hold_valid;
  logic                  r_overflow;
  logic                  r_pend_upd;
  logic                  w_full;
  logic                  w_wr_en;
  logic                  w_pop;
  logic                  w_ovf_set;

  // Fullness is judged on the pre-pop count, so a STORE racing a pop into a full FIFO still drops.
  assign w_full    = (r_count == FULL_CNT);
  assign w_wr_en   = (r_state == STORE) && !w_full;
  assign w_pop     = rd_pop_i && (r_count != '0);
  assign w_ovf_set = (rx_done_i && r_hold_valid) || ((r_state == STORE) && w_full);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (r_hold_valid)    w_next_state = STORE;
        else if (r_pend_upd) w_next_state = FLAG;
      end
      STORE:   w_next_state = FLAG;
      FLAG:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    sel_control      = 1'b0;
    we_reg_control_o = 1'b0;
    if (r_state == FLAG) begin
      sel_control      = 1'b1;
      we_reg_control_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (rx_done_i && !r_hold_valid) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= rx_data_i;
    end else if (r_state == STORE) begin
      r_hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= r_hold_data;
  end

  // New events beat both the CPU clear and the FLAG acknowledge, so nothing is ever lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_overflow <= 1'b0;
      r_pend_upd <= 1'b0;
    end else begin
      if (w_ovf_set)      r_overflow <= 1'b1;
      else if (ovf_clr_i) r_overflow <= 1'b0;

      if (w_ovf_set || w_pop || ovf_clr_i) r_pend_upd <= 1'b1;
      else if (r_state == FLAG)            r_pend_upd <= 1'b0;
    end
  end

  assign rx_data_o     = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign rx_empty_o    = (r_count == '0);
  assign rx_count_o    = r_count;
  assign ctrl_status_o = {r_overflow, (r_count != '0)};

`ifdef RX_UART_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_irq <= 1'b0;
    else       r_irq <= (r_count != '0) | r_overflow;
  end

  assign irq_o = r_irq;
`endif

endmodule

// File: tb/tb_rx_uart_ctrl.sv
// Testbench for rx_uart_ctrl: directed scenarios plus a randomized run against a queue-based reference model.
module tb_rx_uart_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          rx_done_i;
  logic [DW-1:0] rx_data_i;
  logic          rd_pop_i;
  logic          ovf_clr_i;
  logic [DW-1:0] rx_data_o;
  logic          rx_empty_o;
  logic [CW-1:0] rx_count_o;
  logic [1:0]    ctrl_status_o;
  logic          sel_control;
  logic          we_reg_control_o;
`ifdef RX_UART_IRQ_EN
  logic          irq_o;
`endif

  always #5 clk_i = ~clk_i;

  rx_uart_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .rx_done_i        (rx_done_i),
    .rx_data_i        (rx_data_i),
    .rd_pop_i         (rd_pop_i),
    .ovf_clr_i        (ovf_clr_i),
    .rx_data_o        (rx_data_o),
    .rx_empty_o       (rx_empty_o),
    .rx_count_o       (rx_count_o),
    .ctrl_status_o    (ctrl_status_o),
    .sel_control      (sel_control),
    .we_reg_control_o (we_reg_control_o)
`ifdef RX_UART_IRQ_EN
    ,
    .irq_o            (irq_o)
`endif
  );

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model: FIFO contents as a queue, the one-byte holding slot, sticky flags,
  // and what the controller does this cycle (0 free, 1 storing the held byte, 2 writing status).
  logic [DW-1:0] mq[$];
  bit            mOvf;
  bit            mHoldV;
  logic [DW-1:0] mHoldD;
  bit            mPend;
  int            mPhase;
  bit            mIrq;

  function automatic void modelReset();
    mq.delete();
    mOvf   = 1'b0;
    mHoldV = 1'b0;
    mHoldD = '0;
    mPend  = 1'b0;
    mPhase = 0;
    mIrq   = 1'b0;
  endfunction

  function automatic void modelStep(input bit done, input logic [DW-1:0] data, input bit pop, input bit clr);
    int sz         = mq.size();
    bit storing    = (mPhase == 1);
    bit popOk      = pop && (sz > 0);
    bit dropFull   = storing && (sz == DEPTH);
    bit ovfEvent   = (done && mHoldV) || dropFull;
    int nextPhase;
    mIrq = (sz != 0) || mOvf;
    if (mPhase == 1)      nextPhase = 2;
    else if (mPhase == 2) nextPhase = 0;
    else if (mHoldV)      nextPhase = 1;
    else if (mPend)       nextPhase = 2;
    else                  nextPhase = 0;
    if (popOk) void'(mq.pop_front());
    if (storing && !dropFull) mq.push_back(mHoldD);
    if (done && !mHoldV) begin
      mHoldD = data;
      mHoldV = 1'b1;
    end else if (storing) begin
      mHoldV = 1'b0;
    end
    if (ovfEvent) mOvf = 1'b1;
    else if (clr) mOvf = 1'b0;
    if (ovfEvent || popOk || clr) mPend = 1'b1;
    else if (mPhase == 2)         mPend = 1'b0;
    mPhase = nextPhase;
  endfunction

  task automatic applyStimulus(input bit done, input logic [DW-1:0] data, input bit pop, input bit clr);
    rx_done_i = done;
    rx_data_i = data;
    rd_pop_i  = pop;
    ovf_clr_i = clr;
    @(posedge clk_i);
    modelStep(done, data, pop, clr);
    #1;
    rx_done_i = 1'b0;
    rd_pop_i  = 1'b0;
    ovf_clr_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic applyReset();
    rst_i = 1'b1;
    @(posedge clk_i);
    modelReset();
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    modelReset();
    #1;
    rst_i = 1'b0;
    nCompared++;
    if (rx_empty_o !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL reset_empty: got %b want 1", rx_empty_o);
    end
    nCompared++;
    if ({rx_data_o, rx_count_o, ctrl_status_o, sel_control, we_reg_control_o} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs: data=%h count=%0d status=%b sel=%b we=%b want all 0",
               rx_data_o, rx_count_o, ctrl_status_o, sel_control, we_reg_control_o);
    end
  endtask

  // Pulse in cycle N: FIFO written at the end of N+2, status write strobe during N+3.
  task automatic test_single_byte();
    idle(6);
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    idle(1);
    nCompared++;
    if ({sel_control, we_reg_control_o, rx_count_o} !== {2'b00, 3'd0}) begin
      nMismatched++;
      $display("[TB] FAIL single_early: sel=%b we=%b count=%0d want 0 0 0", sel_control, we_reg_control_o, rx_count_o);
    end
    idle(1);
    nCompared++;
    if ({sel_control, we_reg_control_o, ctrl_status_o} !== 4'b1101) begin
      nMismatched++;
      $display("[TB] FAIL single_flag: sel=%b we=%b status=%b want 1 1 01", sel_control, we_reg_control_o, ctrl_status_o);
    end
    nCompared++;
    if ({rx_data_o, rx_count_o} !== {8'hA5, 3'd1}) begin
      nMismatched++;
      $display("[TB] FAIL single_data: data=%h count=%0d want a5 1", rx_data_o, rx_count_o);
    end
    idle(1);
    nCompared++;
    if ({sel_control, we_reg_control_o} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL single_flag_once: sel=%b we=%b want 0 0", sel_control, we_reg_control_o);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    idle(4);
  endtask

  task automatic test_overflow_fill();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
      if (i == 4) begin
        idle(2);
        nCompared++;
        if ({sel_control, we_reg_control_o, ctrl_status_o} !== 4'b1111) begin
          nMismatched++;
          $display("[TB] FAIL fill_drop_flag: sel=%b we=%b status=%b want 1 1 11", sel_control, we_reg_control_o, ctrl_status_o);
        end
        idle(17);
      end else begin
        idle(19);
      end
    end
    nCompared++;
    if ({rx_data_o, rx_count_o, ctrl_status_o} !== {8'h11, 3'd4, 2'b11}) begin
      nMismatched++;
      $display("[TB] FAIL fill_state: data=%h count=%0d status=%b want 11 4 11", rx_data_o, rx_count_o, ctrl_status_o);
    end
  endtask

  task automatic test_pop_drain();
    for (int i = 0; i < 4; i++) begin
      nCompared++;
      if (rx_data_o !== 8'h11 + 8'(i)) begin
        nMismatched++;
        $display("[TB] FAIL drain_head%0d: got %h want %h", i, rx_data_o, 8'h11 + 8'(i));
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      nCompared++;
      if ({rx_count_o, rx_empty_o} !== {3'(3 - i), (i == 3)}) begin
        nMismatched++;
        $display("[TB] FAIL drain_count%0d: count=%0d empty=%b want %0d %b", i, rx_count_o, rx_empty_o, 3 - i, (i == 3));
      end
      idle(1);
      nCompared++;
      if ({sel_control, we_reg_control_o, ctrl_status_o} !== {2'b11, 1'b1, (i != 3)}) begin
        nMismatched++;
        $display("[TB] FAIL drain_flag%0d: sel=%b we=%b status=%b want 1 1 1%b",
                 i, sel_control, we_reg_control_o, ctrl_status_o, (i != 3));
      end
      idle(2);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    idle(1);
    nCompared++;
    if ({sel_control, we_reg_control_o, ctrl_status_o} !== 4'b1100) begin
      nMismatched++;
      $display("[TB] FAIL clear_flag: sel=%b we=%b status=%b want 1 1 00", sel_control, we_reg_control_o, ctrl_status_o);
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    idle(6);
    nCompared++;
    if ({rx_data_o, rx_count_o, ctrl_status_o} !== {8'h3C, 3'd1, 2'b11}) begin
      nMismatched++;
      $display("[TB] FAIL b2b_state: data=%h count=%0d status=%b want 3c 1 11", rx_data_o, rx_count_o, ctrl_status_o);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    idle(3);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    idle(4);
    nCompared++;
    if ({rx_empty_o, ctrl_status_o} !== 3'b100) begin
      nMismatched++;
      $display("[TB] FAIL b2b_cleanup: empty=%b status=%b want 1 00", rx_empty_o, ctrl_status_o);
    end
  endtask

  task automatic test_empty_pop();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      nCompared++;
      if ({rx_count_o, sel_control, we_reg_control_o} !== '0) begin
        nMismatched++;
        $display("[TB] FAIL empty_pop%0d: count=%0d sel=%b we=%b want 0 0 0", i, rx_count_o, sel_control, we_reg_control_o);
      end
      idle(1);
    end
  endtask

  // A pop landing exactly on the STORE cycle leaves the count where it was.
  task automatic test_pop_with_store();
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
    idle(6);
    applyStimulus(1'b1, 8'hB2, 1'b0, 1'b0);
    idle(6);
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    idle(1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    nCompared++;
    if ({rx_count_o, rx_data_o} !== {3'd2, 8'hB2}) begin
      nMismatched++;
      $display("[TB] FAIL pop_store: count=%0d head=%h want 2 b2", rx_count_o, rx_data_o);
    end
    idle(4);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      idle(4);
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    applyReset();
    for (int i = 0; i < 5; i++) begin
      nCompared++;
      if ({rx_empty_o, rx_count_o, sel_control, we_reg_control_o} !== {1'b1, 3'd0, 2'b00}) begin
        nMismatched++;
        $display("[TB] FAIL reset_mid%0d: empty=%b count=%0d sel=%b we=%b want 1 0 0 0",
                 i, rx_empty_o, rx_count_o, sel_control, we_reg_control_o);
      end
      idle(1);
    end
  endtask

  task automatic test_random();
    logic [15:0] got;
    logic [15:0] expV;
    int          sz;
    applyReset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        applyReset();
      end else begin
        applyStimulus($urandom_range(0, 5) == 0, 8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0);
      end
      sz   = mq.size();
      got  = {rx_data_o, rx_empty_o, rx_count_o, ctrl_status_o, sel_control, we_reg_control_o};
      expV = {(sz != 0) ? mq[0] : 8'h00, (sz == 0), 3'(sz), mOvf, (sz != 0), (mPhase == 2), (mPhase == 2)};
      nCompared++;
      if (got !== expV) begin
        nMismatched++;
        $display("[TB] FAIL random_cycle%0d: {data,empty,count,status,sel,we} got %h want %h", i, got, expV);
      end
`ifdef RX_UART_IRQ_EN
      nCompared++;
      if (irq_o !== mIrq) begin
        nMismatched++;
        $display("[TB] FAIL random_irq%0d: got %b want %b", i, irq_o, mIrq);
      end
`endif
    end
  endtask

  initial begin
    rst_i     = 1'b1;
    rx_done_i = 1'b0;
    rx_data_i = '0;
    rd_pop_i  = 1'b0;
    ovf_clr_i = 1'b0;
    modelReset();
    test_reset();
    test_single_byte();
    test_overflow_fill();
    test_pop_drain();
    test_back_to_back();
    test_empty_pop();
    test_pop_with_store();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
